// File: rtl/jet_clus_pkg.sv
// Shared widths, defaults and FSM encoding for the eta clustering scan.
package jet_clus_pkg;

    localparam int NBINS_DEF = 32;

    // Per-bin field widths as returned by the fill stage.
    localparam int ETA_W  = 5;
    localparam int PT_W   = 9;
    localparam int NTRX_W = 5;
    localparam int XC_W   = 4;

    // Cluster sum widths: three saturated bins never overflow these.
    localparam int CPT_W   = 11;
    localparam int CNTRX_W = 7;
    localparam int CNX_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/clus_window.sv
// Three-bin sliding window (prev, cur, next) with local-maximum seed test.
// "next" is the bin arriving this cycle (zero on flush), so the seed decision
// for the centre bin is made in the same cycle its right neighbour arrives.
// Optional: ETA_CLUS_XCOUNT_EN builds the special-track window and sum.
module clus_window
    import jet_clus_pkg::*;
#(
    parameter logic [PT_W-1:0] PT_THRESH = 9'd2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                shift,
    input  logic                flush,
    input  logic [PT_W-1:0]     pt_in,
    input  logic [NTRX_W-1:0]   ntrx_in,
    input  logic [XC_W-1:0]     xc_in,
    output logic                seed,
    output logic [CPT_W-1:0]    sum_pt,
    output logic [CNTRX_W-1:0]  sum_ntrx,
    output logic [CNX_W-1:0]    sum_nx
);

    logic [PT_W-1:0]   prev_pt_q, prev_pt_d, cur_pt_q, cur_pt_d, nxt_pt;
    logic [NTRX_W-1:0] prev_nt_q, prev_nt_d, cur_nt_q, cur_nt_d, nxt_nt;
    logic              step;

    assign step = shift | flush;

    // Incoming bin, forced to zero when flushing past the last bin.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        nxt_pt = '0;
        nxt_nt = '0;
        if (shift) begin
            nxt_pt = pt_in;
            nxt_nt = ntrx_in;
        end
    end

    // Window advance: cur moves to prev, incoming bin becomes cur.
    always_comb begin
        prev_pt_d = prev_pt_q;
        prev_nt_d = prev_nt_q;
        cur_pt_d  = cur_pt_q;
        cur_nt_d  = cur_nt_q;
        if (step) begin
            prev_pt_d = cur_pt_q;
            prev_nt_d = cur_nt_q;
            cur_pt_d  = nxt_pt;
            cur_nt_d  = nxt_nt;
        end
    end

    // Window registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            prev_pt_q <= '0;
            prev_nt_q <= '0;
            cur_pt_q  <= '0;
            cur_nt_q  <= '0;
        end else begin
            prev_pt_q <= prev_pt_d;
            prev_nt_q <= prev_nt_d;
            cur_pt_q  <= cur_pt_d;
            cur_nt_q  <= cur_nt_d;
        end
    end

    // Seed: above threshold, strictly above left neighbour, not below right one.
    assign seed = step
                  && (cur_pt_q >= PT_THRESH)
                  && (cur_pt_q >  prev_pt_q)
                  && (cur_pt_q >= nxt_pt);

    assign sum_pt   = CPT_W'(prev_pt_q) + CPT_W'(cur_pt_q) + CPT_W'(nxt_pt);
    assign sum_ntrx = CNTRX_W'(prev_nt_q) + CNTRX_W'(cur_nt_q) + CNTRX_W'(nxt_nt);

`ifdef ETA_CLUS_XCOUNT_EN
    logic [XC_W-1:0] prev_xc_q, prev_xc_d, cur_xc_q, cur_xc_d, nxt_xc;

    // Special-track count follows the same window as pT.
    always_comb begin
        nxt_xc    = shift ? xc_in : '0;
        prev_xc_d = prev_xc_q;
        cur_xc_d  = cur_xc_q;
        if (step) begin
            prev_xc_d = cur_xc_q;
            cur_xc_d  = nxt_xc;
        end
    end

    // Special-track window registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_xc_q <= '0;
            cur_xc_q  <= '0;
        end else begin
            prev_xc_q <= prev_xc_d;
            cur_xc_q  <= cur_xc_d;
        end
    end

    assign sum_nx = CNX_W'(prev_xc_q) + CNX_W'(cur_xc_q) + CNX_W'(nxt_xc);
`else
    logic unused_xc;
    assign unused_xc = ^xc_in;
    assign sum_nx    = '0;
`endif

endmodule

// File: rtl/eta_cluster_scan.sv
// Clustering-phase sequencer: scans all eta bins of the fill stage once,
// realigns the returned data with a valid delay line and registers one
// cluster per local-maximum seed bin.
// Optional: ETA_CLUS_XCOUNT_EN sums xcount into clus_nx (otherwise 0).
module eta_cluster_scan
    import jet_clus_pkg::*;
#(
    parameter int              NBINS     = NBINS_DEF,
    parameter int              RD_LAT    = 3,
    parameter logic [PT_W-1:0] PT_THRESH = 9'd2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                clustering,
    output logic [ETA_W-1:0]    readeta,
    input  logic [PT_W-1:0]     E_tot,
    input  logic [NTRX_W-1:0]   ntrx,
    input  logic [XC_W-1:0]     xcount,
    output logic                busy,
    output logic                clus_valid,
    output logic [ETA_W-1:0]    clus_eta,
    output logic [CPT_W-1:0]    clus_pt,
    output logic [CNTRX_W-1:0]  clus_ntrx,
    output logic [CNX_W-1:0]    clus_nx,
    output logic                done
);

    scan_state_e         state_q, state_d;
    logic [ETA_W-1:0]    cnt_q, cnt_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [ETA_W-1:0]    cur_eta_q, cur_eta_d;
    logic                clus_valid_q, clus_valid_d;
    logic [ETA_W-1:0]    clus_eta_q, clus_eta_d;
    logic [CPT_W-1:0]    clus_pt_q, clus_pt_d;
    logic [CNTRX_W-1:0]  clus_ntrx_q, clus_ntrx_d;
    logic [CNX_W-1:0]    clus_nx_q, clus_nx_d;

    logic                in_scan, shift, flush, seed;
    logic [CPT_W-1:0]    sum_pt;
    logic [CNTRX_W-1:0]  sum_ntrx;
    logic [CNX_W-1:0]    sum_nx;

    assign in_scan = (state_q == ST_SCAN);
    // Data for the read issued RD_LAT cycles ago is at the inputs now.
    assign shift   = vld_q[RD_LAT-1];
    // One cycle after the last bin arrives, evaluate it against a zero bin.
    assign flush   = (state_q == ST_DRAIN) && (cnt_q == ETA_W'(RD_LAT));

    // FSM next state and address / drain counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ETA_W'(NBINS - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ETA_W'(RD_LAT + 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Valid delay line and index of the bin currently at the window centre.
    always_comb begin
        vld_d[0] = in_scan;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
        cur_eta_d = cur_eta_q;
        if (state_q == ST_IDLE && start) cur_eta_d = '1;   // centre starts at bin -1
        else if (shift)                  cur_eta_d = cur_eta_q + 1'b1;
    end

    // Cluster output register; data fields hold between strobes.
    always_comb begin
        clus_valid_d = seed;
        clus_eta_d   = clus_eta_q;
        clus_pt_d    = clus_pt_q;
        clus_ntrx_d  = clus_ntrx_q;
        clus_nx_d    = clus_nx_q;
        if (seed) begin
            clus_eta_d  = cur_eta_q;
            clus_pt_d   = sum_pt;
            clus_ntrx_d = sum_ntrx;
            clus_nx_d   = sum_nx;
        end
    end

    // All top-level state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            vld_q        <= '0;
            cur_eta_q    <= '0;
            clus_valid_q <= 1'b0;
            clus_eta_q   <= '0;
            clus_pt_q    <= '0;
            clus_ntrx_q  <= '0;
            clus_nx_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vld_q        <= vld_d;
            cur_eta_q    <= cur_eta_d;
            clus_valid_q <= clus_valid_d;
            clus_eta_q   <= clus_eta_d;
            clus_pt_q    <= clus_pt_d;
            clus_ntrx_q  <= clus_ntrx_d;
            clus_nx_q    <= clus_nx_d;
        end
    end

    clus_window #(
        .PT_THRESH (PT_THRESH)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .shift    (shift),
        .flush    (flush),
        .pt_in    (E_tot),
        .ntrx_in  (ntrx),
        .xc_in    (xcount),
        .seed     (seed),
        .sum_pt   (sum_pt),
        .sum_ntrx (sum_ntrx),
        .sum_nx   (sum_nx)
    );

    assign clustering = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign readeta    = in_scan ? cnt_q : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign clus_valid = clus_valid_q;
    assign clus_eta   = clus_eta_q;
    assign clus_pt    = clus_pt_q;
    assign clus_ntrx  = clus_ntrx_q;
    assign clus_nx    = clus_nx_q;

endmodule
